// File: rtl/bus_access_unit.sv
// bus_access_unit: sized load/store sequencer from the CPU datapath onto an Avalon-style bus.
// Define BAU_TIMEOUT_EN to abort a beat after TIMEOUT consecutive waitrequest cycles.
module bus_access_unit #(
    parameter int unsigned BUS_WIDTH  = 32,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned TIMEOUT    = 255
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic                   req_write,
    input  logic [1:0]             req_size,
    input  logic                   req_signed,
    input  logic [ADDR_WIDTH-1:0]  req_addr,
    input  logic [63:0]            req_wdata,
    output logic                   resp_valid,
    output logic                   resp_err,
    output logic [63:0]            resp_rdata,
    output logic [ADDR_WIDTH-1:0]  address,
    output logic                   read,
    output logic                   write,
    input  logic                   waitrequest,
    input  logic [BUS_WIDTH-1:0]   readdata,
    output logic [BUS_WIDTH-1:0]   writedata,
    output logic [BUS_WIDTH/8-1:0] byteenable
);
    localparam int unsigned NB   = BUS_WIDTH / 8;
    localparam int unsigned OFFW = $clog2(NB);

    typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] address_q, address_d;
    logic                  read_q, read_d;
    logic                  write_q, write_d;
    logic [BUS_WIDTH-1:0]  writedata_q, writedata_d;
    logic [NB-1:0]         byteenable_q, byteenable_d;
    logic                  resp_valid_q, resp_valid_d;
    logic                  resp_err_q, resp_err_d;
    logic [63:0]           resp_rdata_q, resp_rdata_d;
    logic [1:0]            size_q, size_d;
    logic                  signed_q, signed_d;
    logic [OFFW-1:0]       off_q, off_d;
    logic                  two_beat_q, two_beat_d;
    logic                  beat_q, beat_d;
    logic [31:0]           wdata_lo_q, wdata_lo_d;
    logic [31:0]           rd_hi_q, rd_hi_d;

`ifdef BAU_TIMEOUT_EN
    localparam int unsigned CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0]         wait_cnt_q, wait_cnt_d;
`else
    logic                  unused_timeout;
    assign unused_timeout = ^32'(TIMEOUT);
`endif

    // Request decode: size in bytes, alignment, lane offset and bus-side steering.
    logic [3:0]            req_bytes;
    logic                  misaligned;
    logic                  req_two;
    logic [OFFW-1:0]       req_off;
    logic [63:0]           wmask;
    logic [BUS_WIDTH-1:0]  lane_wdata;
    logic [NB-1:0]         lane_be;

    always_comb begin
        req_bytes  = 4'(1) << req_size;
        misaligned = (req_addr[2:0] & 3'(req_bytes - 4'(1))) != 3'b000;
        req_two    = (BUS_WIDTH == 32) && (req_size == 2'd3);
        req_off    = req_addr[OFFW-1:0];
        wmask      = (64'(1) << {req_bytes, 3'b000}) - 64'(1);
        lane_wdata = req_two ? BUS_WIDTH'(req_wdata >> 32)
                             : BUS_WIDTH'((req_wdata & wmask) << {req_off, 3'b000});
        lane_be    = NB'(((16'(1) << req_bytes) - 16'(1)) << req_off);
    end

    function automatic logic [63:0] extend(input logic [63:0] raw, input logic [1:0] size,
                                           input logic sgn);
        logic [63:0] r;
        case (size)
            2'd0:    r = {{56{sgn & raw[7]}}, raw[7:0]};
            2'd1:    r = {{48{sgn & raw[15]}}, raw[15:0]};
            2'd2:    r = {{32{sgn & raw[31]}}, raw[31:0]};
            default: r = raw;
        endcase
        return r;
    endfunction

    always_comb begin
        state_d      = state_q;
        address_d    = address_q;
        read_d       = read_q;
        write_d      = write_q;
        writedata_d  = writedata_q;
        byteenable_d = byteenable_q;
        resp_valid_d = 1'b0;
        resp_err_d   = 1'b0;
        resp_rdata_d = 64'd0;
        size_d       = size_q;
        signed_d     = signed_q;
        off_d        = off_q;
        two_beat_d   = two_beat_q;
        beat_d       = beat_q;
        wdata_lo_d   = wdata_lo_q;
        rd_hi_d      = rd_hi_q;
`ifdef BAU_TIMEOUT_EN
        wait_cnt_d   = wait_cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    size_d     = req_size;
                    signed_d   = req_signed;
                    off_d      = req_off;
                    two_beat_d = req_two;
                    beat_d     = 1'b0;
                    wdata_lo_d = req_wdata[31:0];
                    if (misaligned) begin
                        state_d      = RESP;
                        resp_valid_d = 1'b1;
                        resp_err_d   = 1'b1;
                    end else begin
                        state_d      = BUS;
                        read_d       = !req_write;
                        write_d      = req_write;
                        address_d    = {req_addr[ADDR_WIDTH-1:OFFW], OFFW'(0)};
                        byteenable_d = lane_be;
                        writedata_d  = lane_wdata;
`ifdef BAU_TIMEOUT_EN
                        wait_cnt_d   = '0;
`endif
                    end
                end
            end
            BUS: begin
                if (!waitrequest) begin
                    if (two_beat_q && !beat_q) begin
                        // High word arrived; low word follows at the next bus address with no gap.
                        beat_d      = 1'b1;
                        address_d   = address_q + ADDR_WIDTH'(NB);
                        writedata_d = BUS_WIDTH'(wdata_lo_q);
                        rd_hi_d     = readdata[31:0];
`ifdef BAU_TIMEOUT_EN
                        wait_cnt_d  = '0;
`endif
                    end else begin
                        read_d       = 1'b0;
                        write_d      = 1'b0;
                        state_d      = RESP;
                        resp_valid_d = 1'b1;
                        if (read_q) begin
                            resp_rdata_d = extend(two_beat_q ? {rd_hi_q, readdata[31:0]}
                                                             : 64'(readdata >> {off_q, 3'b000}),
                                                  size_q, signed_q);
                        end
                    end
                end
`ifdef BAU_TIMEOUT_EN
                else if (wait_cnt_q == CW'(TIMEOUT - 1)) begin
                    read_d       = 1'b0;
                    write_d      = 1'b0;
                    state_d      = RESP;
                    resp_valid_d = 1'b1;
                    resp_err_d   = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q + CW'(1);
                end
`endif
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            address_q    <= '0;
            read_q       <= 1'b0;
            write_q      <= 1'b0;
            writedata_q  <= '0;
            byteenable_q <= '0;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= 64'd0;
            size_q       <= 2'd0;
            signed_q     <= 1'b0;
            off_q        <= '0;
            two_beat_q   <= 1'b0;
            beat_q       <= 1'b0;
            wdata_lo_q   <= 32'd0;
            rd_hi_q      <= 32'd0;
`ifdef BAU_TIMEOUT_EN
            wait_cnt_q   <= '0;
`endif
        end else begin
            state_q      <= state_d;
            address_q    <= address_d;
            read_q       <= read_d;
            write_q      <= write_d;
            writedata_q  <= writedata_d;
            byteenable_q <= byteenable_d;
            resp_valid_q <= resp_valid_d;
            resp_err_q   <= resp_err_d;
            resp_rdata_q <= resp_rdata_d;
            size_q       <= size_d;
            signed_q     <= signed_d;
            off_q        <= off_d;
            two_beat_q   <= two_beat_d;
            beat_q       <= beat_d;
            wdata_lo_q   <= wdata_lo_d;
            rd_hi_q      <= rd_hi_d;
`ifdef BAU_TIMEOUT_EN
            wait_cnt_q   <= wait_cnt_d;
`endif
        end
    end

    assign req_ready  = (state_q == IDLE);
    assign address    = address_q;
    assign read       = read_q;
    assign write      = write_q;
    assign writedata  = writedata_q;
    assign byteenable = byteenable_q;
    assign resp_valid = resp_valid_q;
    assign resp_err   = resp_err_q;
    assign resp_rdata = resp_rdata_q;

endmodule

// File: tb/tb_bus_access_unit.sv
// tb_bus_access_unit: scoreboard bench for bus_access_unit on a 32-bit bus, backed by a byte memory model.
// With BAU_TIMEOUT_EN defined it also exercises the waitrequest timeout (TIMEOUT=4).
module tb_bus_access_unit;
    localparam int unsigned BW = 32;
    localparam int unsigned AW = 32;
    localparam int unsigned NB = BW / 8;
    localparam int unsigned TO = 4;

    logic          clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset;
    logic          req_valid, req_ready, req_write, req_signed;
    logic [1:0]    req_size;
    logic [AW-1:0] req_addr;
    logic [63:0]   req_wdata;
    logic          resp_valid, resp_err;
    logic [63:0]   resp_rdata;
    logic [AW-1:0] address;
    logic          read, write, waitrequest;
    logic [BW-1:0] readdata, writedata;
    logic [NB-1:0] byteenable;

    bus_access_unit #(.BUS_WIDTH(BW), .ADDR_WIDTH(AW), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
        .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_err(resp_err), .resp_rdata(resp_rdata),
        .address(address), .read(read), .write(write), .waitrequest(waitrequest),
        .readdata(readdata), .writedata(writedata), .byteenable(byteenable)
    );

    typedef struct { logic err; logic [63:0] rdata; int lat; } resp_t;
    typedef struct { logic wr; logic [AW-1:0] addr; logic [NB-1:0] be; logic [BW-1:0] wd; } beat_t;

    resp_t       exp_q[$];
    beat_t       beat_q[$];
    logic [7:0]  ref_mem [bit [31:0]];
    logic [7:0]  bus_mem [bit [31:0]];
    int          n_checks = 0, n_fail = 0;
    int          cyc = 0, accept_cyc = 0, stalls = 0;
    int          wait_pct = 0, force_stall = 0;
    logic        stuck = 1'b0, hold_en = 1'b0;
    logic [31:0] hold_addr = 32'd0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_bound(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: bound expired or unexpected event (t=%0t)", name, $time);
    endtask

    function automatic logic [7:0] init_byte(input logic [31:0] a);
        return 8'((a * 32'd29) ^ (a >> 5) ^ 32'h5A);
    endfunction
    function automatic logic [7:0] ref_rd(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : init_byte(a);
    endfunction
    function automatic logic [7:0] bus_rd(input logic [31:0] a);
        return bus_mem.exists(a) ? bus_mem[a] : init_byte(a);
    endfunction
    task automatic poke(input logic [31:0] a, input logic [7:0] b);
        ref_mem[a] = b;
        bus_mem[a] = b;
    endtask

    // Memory byte holding bits [8j+7:8j] of an n-byte access; a dword on a 32-bit bus keeps its high word first.
    function automatic logic [31:0] byte_addr(input logic [31:0] a, input int j, input int n);
        if (n == 8 && BW == 32) return (j >= 4) ? a + 32'(j - 4) : a + 32'(j + 4);
        return a + 32'(j);
    endfunction

    function automatic logic [63:0] model_load(input logic [31:0] a, input int n, input logic sg);
        logic [63:0] v;
        v = 64'd0;
        for (int j = 0; j < n; j++) v[8*j +: 8] = ref_rd(byte_addr(a, j, n));
        if (sg && n < 8 && v[8*n-1]) v = v | ~((64'd1 << (8*n)) - 64'd1);
        return v;
    endfunction

    task automatic model_store(input logic [31:0] a, input int n, input logic [63:0] wd);
        for (int j = 0; j < n; j++) ref_mem[byte_addr(a, j, n)] = wd[8*j +: 8];
    endtask

    task automatic push_beats(input logic wr, input logic [31:0] a, input int n, input logic [63:0] wd);
        int nbeats;
        nbeats = (8*n + int'(BW) - 1) / int'(BW);
        for (int b = 0; b < nbeats; b++) begin
            beat_t       bt;
            logic [31:0] ba;
            bt.wr   = wr;
            bt.addr = (a & ~32'(NB - 1)) + 32'(b * int'(NB));
            bt.be   = '0;
            bt.wd   = '0;
            for (int j = 0; j < n; j++) begin
                ba = byte_addr(a, j, n);
                if (ba >= bt.addr && ba < bt.addr + NB) begin
                    bt.be[ba - bt.addr]          = 1'b1;
                    bt.wd[8*(ba - bt.addr) +: 8] = wd[8*j +: 8];
                end
            end
            beat_q.push_back(bt);
        end
    endtask

    task automatic start_req(input logic wr, input logic [1:0] sz, input logic sg,
                             input logic [31:0] a, input logic [63:0] wd, input logic to);
        int    n, t;
        resp_t e;
        n       = 1 << sz;
        e.err   = ((a % 32'(n)) != 0) || to;
        e.rdata = (wr || e.err) ? 64'd0 : model_load(a, n, sg);
        e.lat   = e.err ? 1 : (8*n + int'(BW) - 1) / int'(BW) + 1;
        @(negedge clk);
        req_valid  = 1'b1;
        req_write  = wr;
        req_size   = sz;
        req_signed = sg;
        req_addr   = a;
        req_wdata  = wd;
        t = 0;
        while (!req_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (!req_ready) begin
            fail_bound("req_accept");
            req_valid = 1'b0;
            return;
        end
        exp_q.push_back(e);
        if (!e.err) begin
            push_beats(wr, a, n, wr ? wd : 64'd0);
            if (wr) model_store(a, n, wd);
        end
        accept_cyc = cyc;
        stalls     = 0;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_addr  = $urandom;
        req_wdata = {$urandom, $urandom};
        req_size  = 2'($urandom);
    endtask

    task automatic do_req(input logic wr, input logic [1:0] sz, input logic sg,
                          input logic [31:0] a, input logic [63:0] wd, input logic to);
        int t;
        start_req(wr, sz, sg, a, wd, to);
        t = 0;
        while (exp_q.size() != 0 && t < 300) begin
            @(negedge clk);
            t++;
        end
        if (exp_q.size() != 0) begin
            fail_bound("resp_wait");
            exp_q.delete();
            beat_q.delete();
        end
    endtask

    // Bus slave: decides waitrequest each cycle, serves/absorbs completed beats and checks them.
    initial begin
        beat_t b;
        waitrequest = 1'b0;
        readdata    = '0;
        forever begin
            @(posedge clk);
            #1;
            waitrequest = 1'b0;
            if (reset || !(read || write)) continue;
            if (stuck || (hold_en && address == hold_addr) || force_stall > 0 ||
                $urandom_range(0, 99) < wait_pct) begin
                waitrequest = 1'b1;
                readdata    = BW'($urandom);
                stalls++;
                if (force_stall > 0) force_stall--;
            end else if (beat_q.size() == 0) begin
                fail_bound("unexpected_beat");
            end else begin
                b = beat_q.pop_front();
                check("beat_addr", 64'(address), 64'(b.addr));
                check("beat_be", 64'(byteenable), 64'(b.be));
                check("beat_dir", {62'd0, write, read}, b.wr ? 64'd2 : 64'd1);
                if (write) begin
                    check("beat_wdata", 64'(writedata), 64'(b.wd));
                    for (int i = 0; i < int'(NB); i++)
                        if (byteenable[i]) bus_mem[address + 32'(i)] = writedata[8*i +: 8];
                end else begin
                    for (int i = 0; i < int'(NB); i++) readdata[8*i +: 8] = bus_rd(address + 32'(i));
                end
            end
        end
    end

    // Response monitor: every resp_valid pulse must match the oldest expectation, including its cycle.
    initial begin
        resp_t e;
        forever begin
            @(negedge clk);
            if (resp_valid) begin
                if (exp_q.size() == 0) begin
                    fail_bound("unexpected_resp");
                end else begin
                    e = exp_q.pop_front();
                    check("resp_err", 64'(resp_err), 64'(e.err));
                    check("resp_rdata", resp_rdata, e.rdata);
                    check("resp_latency", 64'(cyc - accept_cyc), 64'(e.lat + stalls));
                end
            end
        end
    end

    initial begin
        int t;
        reset      = 1'b1;
        req_valid  = 1'b0;
        req_write  = 1'b0;
        req_size   = 2'd0;
        req_signed = 1'b0;
        req_addr   = '0;
        req_wdata  = 64'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("rst_req_ready", 64'(req_ready), 64'd1);
        check("rst_read", 64'(read), 64'd0);
        check("rst_write", 64'(write), 64'd0);
        check("rst_resp_valid", 64'(resp_valid), 64'd0);
        check("rst_resp_err", 64'(resp_err), 64'd0);
        check("rst_resp_rdata", resp_rdata, 64'd0);
        check("rst_address", 64'(address), 64'd0);
        check("rst_byteenable", 64'(byteenable), 64'd0);
        check("rst_writedata", 64'(writedata), 64'd0);

        // Signed byte load from lane 2.
        poke(32'h1002, 8'h80);
        do_req(1'b0, 2'd0, 1'b1, 32'h1002, 64'd0, 1'b0);
        // Half store to the upper lanes, then read it back both ways.
        do_req(1'b1, 2'd1, 1'b0, 32'h2002, 64'h1234, 1'b0);
        do_req(1'b0, 2'd1, 1'b0, 32'h2002, 64'd0, 1'b0);
        do_req(1'b0, 2'd1, 1'b1, 32'h2002, 64'd0, 1'b0);
        // Two-beat dword load with two stalls on the first beat.
        poke(32'h3000, 8'hDD); poke(32'h3001, 8'hCC); poke(32'h3002, 8'hBB); poke(32'h3003, 8'hAA);
        poke(32'h3004, 8'h44); poke(32'h3005, 8'h33); poke(32'h3006, 8'h22); poke(32'h3007, 8'h11);
        force_stall = 2;
        do_req(1'b0, 2'd3, 1'b0, 32'h3000, 64'd0, 1'b0);
        // Misaligned word and dword: error response, no bus cycle.
        do_req(1'b0, 2'd2, 1'b0, 32'h4001, 64'd0, 1'b0);
        do_req(1'b1, 2'd3, 1'b0, 32'h4004, 64'h0123456789ABCDEF, 1'b0);

        // Reset while the second beat of a dword store is on the bus.
        hold_en   = 1'b1;
        hold_addr = 32'h8004;
        start_req(1'b1, 2'd3, 1'b0, 32'h8000, 64'hCAFEF00D12345678, 1'b0);
        t = 0;
        while (!(write && address == 32'h8004) && t < 50) begin
            @(negedge clk);
            t++;
        end
        check("rst_mid_beat1_addr", 64'(address), 64'h8004);
        exp_q.delete();
        beat_q.delete();
        reset = 1'b1;
        @(negedge clk);
        check("rst_mid_write_drop", 64'(write), 64'd0);
        check("rst_mid_no_resp", 64'(resp_valid), 64'd0);
        reset   = 1'b0;
        hold_en = 1'b0;
        @(negedge clk);
        check("rst_mid_ready", 64'(req_ready), 64'd1);
        check("rst_mid_addr_clear", 64'(address), 64'd0);
        check("rst_mid_write_idle", 64'(write), 64'd0);

`ifdef BAU_TIMEOUT_EN
        stuck = 1'b1;
        do_req(1'b0, 2'd2, 1'b0, 32'h0010, 64'd0, 1'b1);
        stuck = 1'b0;
        check("timeout_read_low", 64'(read), 64'd0);
`endif

        // Randomized traffic over a small window so loads observe earlier stores.
        wait_pct = 25;
        repeat (200) begin
            logic [1:0]  sz;
            logic [31:0] a;
            sz = 2'($urandom_range(0, 3));
            a  = 32'($urandom_range(0, 255));
            if ($urandom_range(0, 3) != 0) a = a & ~(32'(1 << sz) - 32'd1);
            do_req(1'($urandom), sz, 1'($urandom), a, {$urandom, $urandom}, 1'b0);
        end
        wait_pct = 0;
        repeat (3) @(negedge clk);
        check("beat_queue_drained", 64'(beat_q.size()), 64'd0);
        check("final_req_ready", 64'(req_ready), 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
